reg_dump_uart: RTL
==================

Name: reg_dump_uart

Overview:
Debug initiator for the CPU register-readout interface (reg_sel out, reg_data in) of the single-cycle computer top level. On a start pulse it walks reg_sel from 0 to NUM_REGS-1 and captures each register value. It streams a header byte plus all register values out of a UART 8N1 transmit line. It sits beside the CPU at board level and replaces the switch-driven reg_sel.

Parameters:
BAUD_DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2
NUM_REGS, 32, registers dumped per frame, indices 0..NUM_REGS-1; legal range 1..32
HEADER, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock; all logic on the rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
reg_data  input  32  register value for the current reg_sel; combinational from the CPU
reg_sel  output  5  register index driven to the CPU
tx  output  1  UART serial out; idle high
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset (async, rstn=0): state=IDLE, reg_sel=0, tx=1, busy=0, done=0. The hold register, byte counter, bit counter and baud counter all clear.
- Reset mid-frame: tx returns to 1 immediately, with no partial-byte completion. A new dump requires a fresh start.
- Frame = HEADER, then for r = 0..NUM_REGS-1 four bytes of reg r, MSB first (bits 31:24, 23:16, 15:8, 7:0). Total 1+4*NUM_REGS bytes, back-to-back with no idle gap between bytes.
- Byte format: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly BAUD_DIV clk cycles. One byte = 10*BAUD_DIV cycles.
- Main FSM states:
  - IDLE: start=1 -> HDR. reg_sel=0, busy rises next cycle.
  - HDR: transmit HEADER. At the end of its stop bit -> SEL.
  - SEL: reg_sel holds the current index (already driven). Wait exactly 1 cycle for reg_data to settle -> LATCH.
  - LATCH: hold register <= reg_data. Byte index=0 -> SEND.
  - SEND: transmit hold[31-8k:24-8k] for k=0..3. After byte 3's stop bit -> NEXT.
  - NEXT: if reg_sel==NUM_REGS-1 -> DONE. Else reg_sel<=reg_sel+1 -> SEL.
  - DONE: done=1 for one cycle, busy=0, reg_sel<=0 -> IDLE.
- Inter-register gap: SEL+LATCH+NEXT add 3 idle-high clk cycles between the last stop bit of one register and the next start bit. Within a register the 4 bytes are gapless.
- reg_data is sampled only in LATCH. Changes to register contents during SEND do not affect the transmitted bytes.
- start while busy is ignored, with no queuing. start in the same cycle as DONE is also ignored; it is accepted only in IDLE.
- reg_sel is 5 bits and never exceeds NUM_REGS-1. It does not wrap during a frame.
- tx is registered (glitch-free). The baud counter counts 0..BAUD_DIV-1 and advances the bit on terminal count.
- Total frame duration from start accepted to done: (1+4*NUM_REGS)*10*BAUD_DIV + 3*NUM_REGS + 2 cycles. This figure is ±1 cycle for the IDLE and DONE bookkeeping and is fixed by the implementation and documented in the bench.

Test Plan:
1. Reset values: rstn=0 with clk toggling -> tx=1, busy=0, done=0, reg_sel=0. Release, hold start=0 for 100 cycles -> outputs unchanged.
2. Single-reg frame: BAUD_DIV=4, NUM_REGS=1, reg0=32'h12345678, pulse start. Bench UART decoder receives A5,12,34,56,78. Each bit is 4 cycles wide, there is one done pulse, and busy is high throughout.
3. Multi-reg walk: NUM_REGS=3, regs=32'hDEADBEEF, 32'h00000001, 32'h80000000. Bytes received are A5 DE AD BE EF 00 00 00 01 80 00 00 00. reg_sel steps 0,1,2 then returns to 0.
4. Sample-hold: change reg1 from 32'hAAAAAAAA to 32'h55555555 two cycles after LATCH for reg1 -> AA AA AA AA transmitted.
5. start during busy: pulse start mid-frame and in the DONE cycle -> only one frame emitted, byte count 1+4*NUM_REGS. A start 1 cycle after done begins a second frame.
6. Reset mid-byte: assert rstn=0 during data bit 3 of byte 2 -> tx=1 within the same cycle (async), reg_sel=0, busy=0. A following start produces a complete, correct frame.

Source files
------------

// File: rtl/reg_dump_uart.sv
// reg_dump_uart: walks reg_sel over the CPU register file and streams a header byte
// plus every register (MSB byte first) out of a UART 8N1 line.
module reg_dump_uart #(
  parameter int BAUD_DIV = 434,
  parameter int NUM_REGS = 32,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_sel,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam int BW = $clog2(BAUD_DIV);
  typedef enum logic [2:0] {IDLE, HDR, SEL, LATCH, SEND, NEXT, DONE} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud_cnt;
  logic [3:0] bit_cnt;
  logic [1:0] byte_idx;
  logic [31:0] hold;
  logic [7:0] cur_byte;
  logic shifting, tick, byte_end, tx_n;
  assign shifting = state == HDR || state == SEND;
  assign tick = shifting && baud_cnt == BW'(BAUD_DIV - 1);
  assign byte_end = tick && bit_cnt == 4'd9;
  // hold shifts left per byte so the outgoing byte is always its top 8 bits
  assign cur_byte = state == HDR ? HEADER : hold[31:24];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? HDR : IDLE;
      HDR:     state_n = byte_end ? SEL : HDR;
      SEL:     state_n = LATCH;
      LATCH:   state_n = SEND;
      SEND:    state_n = byte_end && byte_idx == 2'd3 ? NEXT : SEND;
      NEXT:    state_n = reg_sel == 5'(NUM_REGS - 1) ? DONE : SEL;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    tx_n = !shifting || bit_cnt == 4'd9 || (bit_cnt != 4'd0 && cur_byte[3'(bit_cnt - 4'd1)]);
    busy = state != IDLE && state != DONE;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      hold     <= '0;
      reg_sel  <= '0;
      tx       <= 1'b1;
    end else begin
      tx <= tx_n;
      baud_cnt <= tick || !shifting ? '0 : baud_cnt + 1'b1;
      if (tick) bit_cnt <= byte_end ? 4'd0 : bit_cnt + 4'd1;
      if (state == LATCH) begin
        hold     <= reg_data;
        byte_idx <= '0;
      end else if (state == SEND && byte_end) begin
        hold     <= {hold[23:0], 8'h00};
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == NEXT && state_n == SEL) reg_sel <= reg_sel + 5'd1;
      else if (state == DONE) reg_sel <= '0;
    end
  end
endmodule
